// File: rtl/spaceship_pkg.sv
// Shared types and geometry for the spaceship movement controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spaceship_pkg;

    localparam int POS_W = 4;
    localparam logic [POS_W-1:0] POS_MIN  = 4'd0;
    localparam logic [POS_W-1:0] POS_MAX  = 4'd15;
    localparam logic [POS_W-1:0] POS_INIT = 4'd7;

    // Player button state machine
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_DELAY  = 3'd2,
        ST_REPEAT = 3'd3,
        ST_BLOCK  = 3'd4
    } move_state_e;

endpackage

// File: rtl/spaceship_move_ctrl_if.sv
// Bundles the controller's button/frame/autopilot inputs and position outputs.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels or single-cycle pulses.
interface spaceship_move_ctrl_if #(
    parameter int POS_W = spaceship_pkg::POS_W
);
    logic             btn_up_n;
    logic             btn_down_n;
    logic             frame_tick;
    logic             freeze;
    logic             auto_en;
    logic [POS_W-1:0] auto_target;
    logic [POS_W-1:0] pos;
    logic             step_up;
    logic             step_down;
    logic             at_min;
    logic             at_max;
    logic             owner;

    // Game logic side: drives controls, observes the ship
    modport master (
        output btn_up_n, btn_down_n, frame_tick, freeze, auto_en, auto_target,
        input  pos, step_up, step_down, at_min, at_max, owner
    );

    // Controller side
    modport slave (
        input  btn_up_n, btn_down_n, frame_tick, freeze, auto_en, auto_target,
        output pos, step_up, step_down, at_min, at_max, owner
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus run-length debouncer for one active-low button.
// Latency: clean level follows the raw pin DEB_CYC+2 cycles after it settles.
// Backpressure: none; free-running level filter.
module btn_debounce #(
    parameter int DEB_CYC = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic clean_n,
    output logic settled
);
    localparam int CNT_W = $clog2(DEB_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

    logic             sync1_q, sync1_d, sync2_q, sync2_d;
    logic             run_q, run_d;
    logic             clean_q, clean_d;
    logic             settled_q, settled_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Track the length of the current run of identical samples; a run of
    // DEB_CYC samples becomes the clean level. settled marks that at least
    // one full run has been seen since reset, so reset values are not trusted.
    always_comb begin
        sync1_d   = btn_n;
        sync2_d   = sync1_q;
        run_d     = run_q;
        cnt_d     = cnt_q;
        clean_d   = clean_q;
        settled_d = settled_q;
        if (sync2_q != run_q) begin
            run_d = sync2_q;
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_LAST) begin
            clean_d   = run_d;
            settled_d = 1'b1;
        end
    end

    // State registers; everything idles at "released"
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            run_q     <= 1'b1;
            cnt_q     <= '0;
            clean_q   <= 1'b1;
            settled_q <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            run_q     <= run_d;
            cnt_q     <= cnt_d;
            clean_q   <= clean_d;
            settled_q <= settled_d;
        end
    end

    assign clean_n = clean_q;
    assign settled = settled_q;
endmodule

// File: rtl/spaceship_move_ctrl.sv
// Spaceship position register driven by debounced buttons with auto-repeat, or by an autopilot.
// Latency: pos and step pulses update one cycle after a step decision; buttons add DEB_CYC+3 cycles.
// Backpressure: none; freeze suppresses movement, steps at the rails are dropped.
module spaceship_move_ctrl #(
    parameter int               POS_W    = spaceship_pkg::POS_W,
    parameter logic [POS_W-1:0] POS_MIN  = POS_W'(spaceship_pkg::POS_MIN),
    parameter logic [POS_W-1:0] POS_MAX  = POS_W'(spaceship_pkg::POS_MAX),
    parameter logic [POS_W-1:0] POS_INIT = POS_W'(spaceship_pkg::POS_INIT),
    parameter int               DEB_CYC  = 16,
    parameter int               RPT_DLY  = 8,
    parameter int               RPT_RATE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spaceship_move_ctrl_if.slave bus
);
    import spaceship_pkg::*;

    localparam int RPT_MAX = (RPT_DLY > RPT_RATE) ? RPT_DLY : RPT_RATE;
    localparam int CNT_W   = $clog2(RPT_MAX + 1);
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(RPT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RPT_RATE - 1);

    logic up_clean_n, dn_clean_n, up_settled, dn_settled;
    logic up_p, dn_p, held, pstep, auto_go, want_up, want_dn;

    move_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;       // 1 = up
    logic             lock_q, lock_d;     // buttons must be released before a new press counts
    logic [POS_W-1:0] pos_q, pos_d;
    logic             step_up_q, step_up_d, step_dn_q, step_dn_d;
    logic             owner_q, owner_d, at_min_q, at_min_d, at_max_q, at_max_d;

    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_up (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_up_n), .clean_n(up_clean_n), .settled(up_settled));
    btn_debounce #(.DEB_CYC(DEB_CYC)) u_deb_dn (
        .clk(clk), .rst_n(rst_n), .btn_n(bus.btn_down_n), .clean_n(dn_clean_n), .settled(dn_settled));

    assign up_p = ~up_clean_n;
    assign dn_p = ~dn_clean_n;
    assign held = dir_q ? up_p : dn_p;

    // Player FSM: freeze beats everything, both-pressed beats per-state moves
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        pstep   = 1'b0;
        if (bus.freeze) begin
            state_d = ST_IDLE;
        end else if (up_p && dn_p) begin
            state_d = ST_BLOCK;
        end else begin
            case (state_q)
                ST_IDLE: if ((up_p ^ dn_p) && !lock_q) begin
                    state_d = ST_FIRST;
                    dir_d   = up_p;
                end
                ST_FIRST: if (!held) state_d = ST_IDLE;
                          else begin pstep = 1'b1; state_d = ST_DELAY; end
                ST_DELAY: if (!held) state_d = ST_IDLE;
                          else if (bus.frame_tick) begin
                              if (cnt_q == DLY_LAST) begin pstep = 1'b1; state_d = ST_REPEAT; end
                              else cnt_d = cnt_q + CNT_W'(1);
                          end
                ST_REPEAT: if (!held) state_d = ST_IDLE;
                           else if (bus.frame_tick) begin
                               if (cnt_q == RATE_LAST) begin pstep = 1'b1; cnt_d = '0; end
                               else cnt_d = cnt_q + CNT_W'(1);
                           end
                ST_BLOCK: if (!up_p && !dn_p) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
        if (state_d != state_q) cnt_d = '0;
    end

    // Press lockout: armed by reset and freeze, cleared once both buttons read released
    always_comb begin
        lock_d = lock_q;
        if (bus.freeze) lock_d = 1'b1;
        else if (!up_p && !dn_p && up_settled && dn_settled) lock_d = 1'b0;
    end

    // Arbitration and saturating position update; a player step always wins
    always_comb begin
        auto_go = (state_q == ST_IDLE) && (state_d == ST_IDLE) && bus.auto_en && !bus.freeze
                  && bus.frame_tick && (pos_q != bus.auto_target);
        want_up   = pstep ? dir_q  : (auto_go && (bus.auto_target > pos_q));
        want_dn   = pstep ? !dir_q : (auto_go && (bus.auto_target < pos_q));
        step_up_d = want_up && (pos_q != POS_MAX);
        step_dn_d = want_dn && (pos_q != POS_MIN);
        pos_d     = pos_q;
        if (step_up_d)      pos_d = pos_q + POS_W'(1);
        else if (step_dn_d) pos_d = pos_q - POS_W'(1);
        owner_d  = (state_d == ST_IDLE) && bus.auto_en && !bus.freeze;
        at_min_d = (pos_d == POS_MIN);
        at_max_d = (pos_d == POS_MAX);
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            lock_q    <= 1'b1;
            pos_q     <= POS_INIT;
            step_up_q <= 1'b0;
            step_dn_q <= 1'b0;
            owner_q   <= 1'b0;
            at_min_q  <= (POS_INIT == POS_MIN);
            at_max_q  <= (POS_INIT == POS_MAX);
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            lock_q    <= lock_d;
            pos_q     <= pos_d;
            step_up_q <= step_up_d;
            step_dn_q <= step_dn_d;
            owner_q   <= owner_d;
            at_min_q  <= at_min_d;
            at_max_q  <= at_max_d;
        end
    end

    assign bus.pos       = pos_q;
    assign bus.step_up   = step_up_q;
    assign bus.step_down = step_dn_q;
    assign bus.owner     = owner_q;
    assign bus.at_min    = at_min_q;
    assign bus.at_max    = at_max_q;
endmodule
